cg_group_bank: RTL and testbench

Parametrised register bank whose flops are split into fixed-size groups, each group sharing one force-merged clock-gate enable. A bit loads `data_in` on `valid`; otherwise it copies its group MSB whenever `last` is low. The bank also keeps enable-activity counters and a frame tracker. It sits in front of the low-power clock-gating flow as the generic replacement for hand-written per-width merge banks.

---
 rtl/cg_bank_pkg.sv | 17 +
 rtl/cg_group_bank_if.sv | 37 +++
 rtl/cg_group_slice.sv | 47 ++++
 rtl/cg_group_bank.sv | 121 ++++++++++++
 tb/tb_cg_group_bank.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cg_bank_pkg.sv
// rtl/cg_bank_pkg.sv - shared types, mode constants and group-MSB helper for cg_group_bank
package cg_bank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frm_state_t;

    localparam logic CG_MODE_MERGED = 1'b0;
    localparam logic CG_MODE_SPLIT  = 1'b1;

    // Bit index of the MSB of group g when each group holds grp bits.
    function automatic int grp_msb(input int g, input int grp);
        return g * grp + grp - 1;
    endfunction

endpackage

// File: rtl/cg_group_bank_if.sv
// rtl/cg_group_bank_if.sv - load/control inputs and bank status outputs of cg_group_bank
// Ports (slave view): valid, last, data_in, grp_mask, mode, clr in;
// out, grp_en, msb_en, en_cnt, red_cnt, busy, frm_cnt out.
interface cg_group_bank_if #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4,
    parameter int CNT_W = 16,
    parameter int FRM_W = 8
);
    localparam int NGRP = WIDTH / GRP;

    logic             valid;
    logic             last;
    logic [WIDTH-1:0] data_in;
    logic [NGRP-1:0]  grp_mask;
    logic             mode;
    logic             clr;

    logic [WIDTH-1:0] out;
    logic [NGRP-1:0]  grp_en;
    logic [NGRP-1:0]  msb_en;
    logic [CNT_W-1:0] en_cnt;
    logic [CNT_W-1:0] red_cnt;
    logic             busy;
    logic [FRM_W-1:0] frm_cnt;

    modport master (
        output valid, last, data_in, grp_mask, mode, clr,
        input  out, grp_en, msb_en, en_cnt, red_cnt, busy, frm_cnt
    );

    modport slave (
        input  valid, last, data_in, grp_mask, mode, clr,
        output out, grp_en, msb_en, en_cnt, red_cnt, busy, frm_cnt
    );

endinterface

// File: rtl/cg_group_slice.sv
// rtl/cg_group_slice.sv - one gated group: flops, merged enable, MSB-copy mux, msb_en
// Ports: clk, rst, valid, last, mask, mode, data_in[GRP] in; q[GRP], grp_en, msb_en out.
module cg_group_slice
    import cg_bank_pkg::*;
#(
    parameter int GRP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic           last,
    input  logic           mask,
    input  logic           mode,
    input  logic [GRP-1:0] data_in,
    output logic [GRP-1:0] q,
    output logic           grp_en,
    output logic           msb_en
);

    logic [GRP-1:0] q_q;
    logic [GRP-1:0] q_d;

    // The MSB copy makes the MSB flop reload its own value, so in split mode
    // only the data load needs to clock the MSB.
    always_comb begin
        grp_en = mask & (valid | ~last);
        msb_en = (mode == CG_MODE_SPLIT) ? (mask & valid) : grp_en;
    end

    always_comb begin
        q_d = q_q;
        if (grp_en) begin
            q_d = valid ? data_in : {GRP{q_q[GRP-1]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cg_group_bank.sv
// rtl/cg_group_bank.sv - grouped clock-gate register bank with activity counters and frame tracker
// Ports: clk, rst (sync, active-high) plus bus (slave modport of cg_group_bank_if).
module cg_group_bank
    import cg_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = 4,
    parameter int CNT_W = 16,
    parameter int FRM_W = 8
) (
    input logic            clk,
    input logic            rst,
    cg_group_bank_if.slave bus
);

    localparam int NGRP = WIDTH / GRP;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FRM_W-1:0] FRM_ONE = 1;

    if (WIDTH % GRP != 0) begin : g_width_check
        $error("cg_group_bank: WIDTH must be a multiple of GRP");
    end

    logic [WIDTH-1:0] out_w;
    logic [NGRP-1:0]  grp_en_w;
    logic [NGRP-1:0]  msb_en_w;

    for (genvar g = 0; g < NGRP; g++) begin : g_slice
        localparam int MSB = grp_msb(g, GRP);
        cg_group_slice #(.GRP(GRP)) u_slice (
            .clk     (clk),
            .rst     (rst),
            .valid   (bus.valid),
            .last    (bus.last),
            .mask    (bus.grp_mask[g]),
            .mode    (bus.mode),
            .data_in (bus.data_in[MSB -: GRP]),
            .q       (out_w[MSB -: GRP]),
            .grp_en  (grp_en_w[g]),
            .msb_en  (msb_en_w[g])
        );
    end

    // Activity counters: clr beats increment, both saturate.
    logic             any_en;
    logic             red_en;
    logic [CNT_W-1:0] en_cnt_q, en_cnt_d;
    logic [CNT_W-1:0] red_cnt_q, red_cnt_d;

    always_comb begin
        any_en    = |grp_en_w;
        red_en    = any_en & ~bus.valid;
        en_cnt_d  = en_cnt_q;
        red_cnt_d = red_cnt_q;
        if (bus.clr) begin
            en_cnt_d  = '0;
            red_cnt_d = '0;
        end else begin
            if (any_en && en_cnt_q != CNT_MAX) begin
                en_cnt_d = en_cnt_q + CNT_ONE;
            end
            if (red_en && red_cnt_q != CNT_MAX) begin
                red_cnt_d = red_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_cnt_q  <= '0;
            red_cnt_q <= '0;
        end else begin
            en_cnt_q  <= en_cnt_d;
            red_cnt_q <= red_cnt_d;
        end
    end

    // Frame FSM: state register / next-state / output.
    frm_state_t       state_q, state_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    // A valid&last beat ends a frame from either state, including single-beat frames.
    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        if (bus.valid) begin
            if (bus.last) begin
                state_d   = IDLE;
                frm_cnt_d = frm_cnt_q + FRM_ONE;
            end else begin
                state_d = ACTIVE;
            end
        end
    end

    logic busy_w;

    always_comb begin
        busy_w = (state_q == ACTIVE);
    end

    assign bus.out     = out_w;
    assign bus.grp_en  = grp_en_w;
    assign bus.msb_en  = msb_en_w;
    assign bus.en_cnt  = en_cnt_q;
    assign bus.red_cnt = red_cnt_q;
    assign bus.busy    = busy_w;
    assign bus.frm_cnt = frm_cnt_q;

endmodule

// File: tb/tb_cg_group_bank.sv
// tb/tb_cg_group_bank.sv - directed self-checking bench for cg_group_bank
module tb_cg_group_bank;

    localparam int WIDTH = 16;
    localparam int GRP   = 4;
    localparam int CNT_W = 4;
    localparam int FRM_W = 8;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    cg_group_bank_if #(.WIDTH(WIDTH), .GRP(GRP), .CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();

    cg_group_bank #(.WIDTH(WIDTH), .GRP(GRP), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid    = 1'b0;
        bus.last     = 1'b1;
        bus.data_in  = '0;
        bus.grp_mask = 4'hF;
        bus.mode     = 1'b0;
        bus.clr      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.last = 1'b0;
        #1;
        total++;
        if (bus.grp_en !== 4'hF) $display("FAIL reset_grp_en_live got %h want %h", bus.grp_en, 4'hF);
        else passed++;
        step();
        step();
        rst = 1'b0;
        bus.last = 1'b1;
        #1;
        total++;
        if (bus.out !== 16'h0) $display("FAIL reset_out got %h want %h", bus.out, 16'h0);
        else passed++;
        total++;
        if (bus.en_cnt !== 4'd0 || bus.red_cnt !== 4'd0)
            $display("FAIL reset_cnts got %0d/%0d want 0/0", bus.en_cnt, bus.red_cnt);
        else passed++;
        total++;
        if (bus.busy !== 1'b0 || bus.frm_cnt !== 8'd0)
            $display("FAIL reset_frame got busy=%b frm=%0d want 0/0", bus.busy, bus.frm_cnt);
        else passed++;
    endtask

    // Load A5C3, MSB-fill with valid=0/last=0, then hold with last=1.
    task automatic test_load_fill_hold();
        do_reset();
        bus.valid   = 1'b1;
        bus.last    = 1'b0;
        bus.data_in = 16'hA5C3;
        #1;
        total++;
        if (bus.grp_en !== 4'hF || bus.msb_en !== 4'hF)
            $display("FAIL load_en got %h/%h want F/F", bus.grp_en, bus.msb_en);
        else passed++;
        step();
        total++;
        if (bus.out !== 16'hA5C3) $display("FAIL load_out got %h want %h", bus.out, 16'hA5C3);
        else passed++;
        total++;
        if (bus.en_cnt !== 4'd1 || bus.red_cnt !== 4'd0 || bus.frm_cnt !== 8'd0)
            $display("FAIL load_cnts got en=%0d red=%0d frm=%0d want 1/0/0", bus.en_cnt, bus.red_cnt, bus.frm_cnt);
        else passed++;

        bus.valid = 1'b0;
        bus.last  = 1'b0;
        bus.mode  = 1'b1;
        #1;
        total++;
        if (bus.grp_en !== 4'hF || bus.msb_en !== 4'h0)
            $display("FAIL split_en got %h/%h want F/0", bus.grp_en, bus.msb_en);
        else passed++;
        step();
        // Group MSBs of A5C3 from group 0 up: 0,1,0,1.
        total++;
        if (bus.out !== 16'hF0F0) $display("FAIL fill_out got %h want %h", bus.out, 16'hF0F0);
        else passed++;
        total++;
        if (bus.en_cnt !== 4'd2 || bus.red_cnt !== 4'd1)
            $display("FAIL fill_cnts got en=%0d red=%0d want 2/1", bus.en_cnt, bus.red_cnt);
        else passed++;
        total++;
        if (bus.busy !== 1'b1) $display("FAIL fill_busy got %b want 1", bus.busy);
        else passed++;

        bus.last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bus.grp_en !== 4'h0 || bus.msb_en !== 4'h0)
                $display("FAIL hold_en[%0d] got %h/%h want 0/0", i, bus.grp_en, bus.msb_en);
            else passed++;
            step();
        end
        total++;
        if (bus.out !== 16'hF0F0) $display("FAIL hold_out got %h want %h", bus.out, 16'hF0F0);
        else passed++;
        total++;
        if (bus.en_cnt !== 4'd2 || bus.red_cnt !== 4'd1)
            $display("FAIL hold_cnts got en=%0d red=%0d want 2/1", bus.en_cnt, bus.red_cnt);
        else passed++;
    endtask

    task automatic test_mask();
        do_reset();
        bus.grp_mask = 4'b0101;
        bus.valid    = 1'b1;
        bus.last     = 1'b1;
        bus.data_in  = 16'hFFFF;
        #1;
        total++;
        if (bus.grp_en !== 4'b0101 || bus.msb_en !== 4'b0101)
            $display("FAIL mask_en got %h/%h want 5/5", bus.grp_en, bus.msb_en);
        else passed++;
        step();
        total++;
        if (bus.out !== 16'h0F0F) $display("FAIL mask_out got %h want %h", bus.out, 16'h0F0F);
        else passed++;
        // Frozen groups must ignore new data even with valid.
        bus.grp_mask = 4'b1010;
        bus.data_in  = 16'h0000;
        step();
        total++;
        if (bus.out !== 16'h0F0F) $display("FAIL mask_freeze_out got %h want %h", bus.out, 16'h0F0F);
        else passed++;
    endtask

    task automatic test_frame();
        logic [1:0] beats [5];
        logic       exp_busy [5];
        beats    = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b11};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.valid = beats[i][1];
            bus.last  = beats[i][0];
            step();
            total++;
            if (bus.busy !== exp_busy[i])
                $display("FAIL frame_busy[%0d] got %b want %b", i, bus.busy, exp_busy[i]);
            else passed++;
        end
        total++;
        if (bus.frm_cnt !== 8'd2) $display("FAIL frame_cnt got %0d want 2", bus.frm_cnt);
        else passed++;
        bus.valid = 1'b1;
        bus.last  = 1'b0;
        step();
        // Reset beats valid&last and clr in the same cycle.
        rst       = 1'b1;
        bus.last  = 1'b1;
        bus.clr   = 1'b1;
        step();
        rst       = 1'b0;
        bus.valid = 1'b0;
        bus.clr   = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.frm_cnt !== 8'd0 || bus.out !== 16'h0)
            $display("FAIL frame_rst got busy=%b frm=%0d out=%h want 0/0/0", bus.busy, bus.frm_cnt, bus.out);
        else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        bus.valid = 1'b1;
        bus.last  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (bus.en_cnt !== 4'd15) $display("FAIL sat_en got %0d want 15", bus.en_cnt);
        else passed++;
        total++;
        if (bus.frm_cnt !== 8'd20) $display("FAIL sat_frm got %0d want 20", bus.frm_cnt);
        else passed++;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        total++;
        if (bus.en_cnt !== 4'd0) $display("FAIL clr_en got %0d want 0", bus.en_cnt);
        else passed++;
        // Redundant counter saturates too, and clr wins over its increment.
        bus.valid = 1'b0;
        bus.last  = 1'b0;
        for (int i = 0; i < 18; i++) step();
        total++;
        if (bus.red_cnt !== 4'd15) $display("FAIL sat_red got %0d want 15", bus.red_cnt);
        else passed++;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        total++;
        if (bus.red_cnt !== 4'd0 || bus.en_cnt !== 4'd0)
            $display("FAIL clr_red got red=%0d en=%0d want 0/0", bus.red_cnt, bus.en_cnt);
        else passed++;
    endtask

    task automatic test_frm_wrap();
        do_reset();
        bus.valid = 1'b1;
        bus.last  = 1'b1;
        for (int i = 0; i < 256; i++) step();
        total++;
        if (bus.frm_cnt !== 8'd0) $display("FAIL frm_wrap got %0d want 0", bus.frm_cnt);
        else passed++;
        step();
        total++;
        if (bus.frm_cnt !== 8'd1) $display("FAIL frm_wrap_next got %0d want 1", bus.frm_cnt);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_load_fill_hold();
        test_mask();
        test_frame();
        test_saturate();
        test_frm_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
